// File: rtl/onehot_encoder_register_pkg.sv
// ---------------------------------------------------------------------------
// onehot_pkg
// Purpose : Shared definitions for the one-hot encoder register slice.
//           Holds the skid-buffer state enum and the default widths used by
//           the interface, the checker and the top module.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package onehot_pkg;

    // Default widths: a 16-bit one-hot vector encodes into a 4-bit index.
    localparam int DEF_INPUT_WIDTH  = 16;
    localparam int DEF_OUTPUT_WIDTH = 4;
    localparam int DEF_ERRCNT_WIDTH = 8;

    // Occupancy of the two-entry skid buffer.
    // EMPTY: nothing held, BUSY: main entry only, FULL: main and skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_encoder_register_if.sv
// ---------------------------------------------------------------------------
// onehot_encoder_register_if
// Purpose : Groups the upstream valid/ready, downstream valid/ready and the
//           enable gate of the one-hot encoder register.
// Signals : enable, in_valid, onehot_in, out_ready   (master -> slave)
//           in_ready, out_valid, binary_out, err_out  (slave -> master)
// Modports: master (traffic source/sink), slave (the encoder register)
// ---------------------------------------------------------------------------
interface onehot_encoder_register_if
    import onehot_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
);

    logic                    enable;
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  onehot_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] binary_out;
    logic                    err_out;

    modport master (
        output enable, in_valid, onehot_in, out_ready,
        input  in_ready, out_valid, binary_out, err_out
    );

    modport slave (
        input  enable, in_valid, onehot_in, out_ready,
        output in_ready, out_valid, binary_out, err_out
    );

endinterface

// File: rtl/onehot_encoder_register_check.sv
// ---------------------------------------------------------------------------
// onehot_check
// Purpose : Purely combinational inspection of a one-hot vector.
// Ports   : i_vec   - vector under test
//           o_index - index of the lowest set bit (0 when no bit is set)
//           o_zero  - no bit set
//           o_multi - more than one bit set
// ---------------------------------------------------------------------------
module onehot_check
    import onehot_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic [INPUT_WIDTH-1:0]  i_vec,
    output logic [OUTPUT_WIDTH-1:0] o_index,
    output logic                    o_zero,
    output logic                    o_multi
);

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        o_index = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = OUTPUT_WIDTH'(i);
            end
        end
    end

    // v & (v - 1) clears the lowest set bit; anything left means multi-hot.
    assign o_zero  = ~|i_vec;
    assign o_multi = |(i_vec & (i_vec - INPUT_WIDTH'(1)));

endmodule

// File: rtl/onehot_encoder_register.sv
// ---------------------------------------------------------------------------
// onehot_encoder_register
// Purpose : Encodes a one-hot vector to the index of its lowest set bit and
//           flags zero-hot/multi-hot inputs, buffering results in a two-entry
//           skid buffer so in_ready never depends on out_ready.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset
//           bus      - onehot_encoder_register_if.slave (handshakes + data)
//           err_clr  - synchronous error-counter clear   (ONEHOT_ENC_ERRCNT_EN)
//           err_count- saturating error count            (ONEHOT_ENC_ERRCNT_EN)
// Config  : `define ONEHOT_ENC_ERRCNT_EN to build the error counter.
// ---------------------------------------------------------------------------
module onehot_encoder_register
    import onehot_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int ERRCNT_WIDTH = DEF_ERRCNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    onehot_encoder_register_if.slave bus
`ifdef ONEHOT_ENC_ERRCNT_EN
    ,
    input  logic                     err_clr,
    output logic [ERRCNT_WIDTH-1:0]  err_count
`endif
);

    // Reject parameter sets that cannot round-trip between vector and index.
    if (INPUT_WIDTH != (2 ** OUTPUT_WIDTH)) begin : g_widthCheck
        $error("onehot_encoder_register: INPUT_WIDTH must equal 2**OUTPUT_WIDTH");
    end
    if (ERRCNT_WIDTH < 1) begin : g_errWidthCheck
        $error("onehot_encoder_register: ERRCNT_WIDTH must be at least 1");
    end

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    r_armed;
    logic [OUTPUT_WIDTH-1:0] r_mainIndex;
    logic                    r_mainErr;
    logic [OUTPUT_WIDTH-1:0] r_skidIndex;
    logic                    r_skidErr;
    logic [OUTPUT_WIDTH-1:0] w_index;
    logic                    w_zero;
    logic                    w_multi;
    logic                    w_err;
    logic                    w_inReady;
    logic                    w_inXfer;
    logic                    w_outXfer;
    logic                    w_loadMain;
    logic                    w_loadSkid;
    logic                    w_moveSkid;

    onehot_check #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_check (
        .i_vec   (bus.onehot_in),
        .o_index (w_index),
        .o_zero  (w_zero),
        .o_multi (w_multi)
    );

    assign w_err = w_zero | w_multi;

    // r_armed keeps in_ready low during reset and releases it on the first
    // clock edge afterwards; in_ready only looks at registered state and enable.
    assign w_inReady      = bus.enable && r_armed && (r_state != FULL);
    assign w_inXfer       = bus.in_valid && w_inReady;
    assign w_outXfer      = (r_state != EMPTY) && bus.out_ready;
    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = (r_state != EMPTY);
    assign bus.binary_out = r_mainIndex;
    assign bus.err_out    = r_mainErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and entry steering. A simultaneous in/out transfer in BUSY
    // reloads main directly; the skid entry is only filled when main is stuck.
    always_comb begin
        w_nextState = r_state;
        w_loadMain  = 1'b0;
        w_loadSkid  = 1'b0;
        w_moveSkid  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inXfer) begin
                    w_nextState = BUSY;
                    w_loadMain  = 1'b1;
                end
            end
            BUSY: begin
                if (w_inXfer && w_outXfer) begin
                    w_loadMain  = 1'b1;
                end else if (w_inXfer) begin
                    w_nextState = FULL;
                    w_loadSkid  = 1'b1;
                end else if (w_outXfer) begin
                    w_nextState = EMPTY;
                end
            end
            FULL: begin
                if (w_outXfer) begin
                    w_nextState = BUSY;
                    w_moveSkid  = 1'b1;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainIndex <= '0;
            r_mainErr   <= 1'b0;
            r_skidIndex <= '0;
            r_skidErr   <= 1'b0;
        end else begin
            if (w_loadMain) begin
                r_mainIndex <= w_index;
                r_mainErr   <= w_err;
            end else if (w_moveSkid) begin
                r_mainIndex <= r_skidIndex;
                r_mainErr   <= r_skidErr;
            end
            if (w_loadSkid) begin
                r_skidIndex <= w_index;
                r_skidErr   <= w_err;
            end
        end
    end

`ifdef ONEHOT_ENC_ERRCNT_EN
    logic [ERRCNT_WIDTH-1:0] r_errCount;

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= '0;
        end else if (err_clr) begin
            r_errCount <= '0;
        end else if (w_inXfer && w_err && (r_errCount != '1)) begin
            r_errCount <= r_errCount + ERRCNT_WIDTH'(1);
        end
    end

    assign err_count = r_errCount;
`endif

endmodule

// File: tb/tb_onehot_encoder_register.sv
// ---------------------------------------------------------------------------
// tb_onehot_encoder_register
// Purpose : Self-checking bench for onehot_encoder_register. A queue-based
//           model (capacity two, FIFO order) predicts every output each
//           cycle; directed scenarios pin literal values on top of it.
// Config  : honours ONEHOT_ENC_ERRCNT_EN for the error counter.
// ---------------------------------------------------------------------------
module tb_onehot_encoder_register;

    typedef struct {
        int idx;
        bit err;
    } result_t;

    logic       clk;
    logic       rst_n;
    logic       errClr;
    logic [7:0] errCount;

    int testsRun    = 0;
    int testsFailed = 0;
    int mdlAccepted = 0;
    int mdlErrCount = 0;
    bit mdlArmed;
    result_t mdlQueue[$];

    onehot_encoder_register_if bus ();

    onehot_encoder_register dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ONEHOT_ENC_ERRCNT_EN
        ,
        .err_clr   (errClr),
        .err_count (errCount)
`endif
    );

`ifndef ONEHOT_ENC_ERRCNT_EN
    assign errCount = 8'd0;
`endif

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value against its expectation and keep the tallies.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge and wait for the
    // edge that consumes them.
    task automatic applyStimulus(input logic v, input logic [15:0] d,
                                 input logic r, input logic e, input logic c);
        bus.in_valid  = v;
        bus.onehot_in = d;
        bus.out_ready = r;
        bus.enable    = e;
        errClr        = c;
        @(posedge clk);
        #1;
    endtask

    // Reference encoding straight from the rules: lowest set bit, 0 for none,
    // error unless exactly one bit is set.
    function automatic result_t encode(input logic [15:0] v);
        result_t res;
        res.idx = 0;
        res.err = ($countones(v) != 1);
        for (int k = 15; k >= 0; k--) begin
            if (v[k]) res.idx = k;
        end
        return res;
    endfunction

    function automatic logic [15:0] randVec();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0, 3:    v = 16'(1) << $urandom_range(0, 15);
            1:       v = 16'h0000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // in_ready is released by the first rising edge seen outside reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdlArmed <= 1'b0;
        else        mdlArmed <= 1'b1;
    end

    // Per-cycle compare on the falling edge, then advance the model with the
    // transfers the next rising edge will perform.
    always @(negedge clk) begin
        result_t res;
        bit      expReady;
        bit      inX;
        bit      outX;
        if (!rst_n) begin
            mdlQueue.delete();
            mdlErrCount = 0;
            checkOutput("rstInReady", 32'(bus.in_ready), 0);
            checkOutput("rstOutValid", 32'(bus.out_valid), 0);
            checkOutput("rstBinary", 32'(bus.binary_out), 0);
            checkOutput("rstErr", 32'(bus.err_out), 0);
`ifdef ONEHOT_ENC_ERRCNT_EN
            checkOutput("rstErrCount", 32'(errCount), 0);
`endif
        end else begin
            expReady = mdlArmed && bus.enable && (mdlQueue.size() < 2);
            checkOutput("inReady", 32'(bus.in_ready), 32'(expReady));
            checkOutput("outValid", 32'(bus.out_valid), 32'(mdlQueue.size() != 0));
            if (mdlQueue.size() != 0) begin
                checkOutput("binaryOut", 32'(bus.binary_out), 32'(mdlQueue[0].idx));
                checkOutput("errOut", 32'(bus.err_out), 32'(mdlQueue[0].err));
            end
`ifdef ONEHOT_ENC_ERRCNT_EN
            checkOutput("errCount", 32'(errCount), 32'(mdlErrCount));
`endif
            inX  = bus.in_valid && expReady;
            outX = (mdlQueue.size() != 0) && bus.out_ready;
            res  = encode(bus.onehot_in);
            if (errClr) mdlErrCount = 0;
            else if (inX && res.err && mdlErrCount < 255) mdlErrCount++;
            if (outX) void'(mdlQueue.pop_front());
            if (inX) begin
                mdlQueue.push_back(res);
                mdlAccepted++;
            end
        end
    end

    // Directed scenarios followed by the randomized run.
    initial begin
        int startAcc;
        int cycles;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.onehot_in = '0;
        bus.out_ready = 1'b0;
        errClr        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutValid", 32'(bus.out_valid), 0);
        checkOutput("resetInReady", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        applyStimulus(0, 16'h0000, 1, 1, 0);
        checkOutput("armedInReady", 32'(bus.in_ready), 1);

        // Single clean vector appears one edge after acceptance.
        applyStimulus(1, 16'h0020, 1, 1, 0);
        checkOutput("s1Valid", 32'(bus.out_valid), 1);
        checkOutput("s1Binary", 32'(bus.binary_out), 5);
        checkOutput("s1Err", 32'(bus.err_out), 0);
        applyStimulus(0, 16'h0000, 1, 1, 0);

        // Zero-hot then multi-hot, back to back with the output draining.
        applyStimulus(1, 16'h0000, 1, 1, 0);
        checkOutput("s2aBinary", 32'(bus.binary_out), 0);
        checkOutput("s2aErr", 32'(bus.err_out), 1);
        applyStimulus(1, 16'h0024, 1, 1, 0);
        checkOutput("s2bBinary", 32'(bus.binary_out), 2);
        checkOutput("s2bErr", 32'(bus.err_out), 1);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("s2Count", 32'(errCount), 2);
`endif
        applyStimulus(0, 16'h0000, 1, 1, 0);

        // Back-pressure fills both entries, then drains in order.
        applyStimulus(1, 16'h0001, 0, 1, 0);
        applyStimulus(1, 16'h0002, 0, 1, 0);
        checkOutput("s3InReadyFull", 32'(bus.in_ready), 0);
        checkOutput("s3HeadBinary", 32'(bus.binary_out), 0);
        applyStimulus(0, 16'h0000, 0, 1, 0);
        checkOutput("s3HoldBinary", 32'(bus.binary_out), 0);
        applyStimulus(0, 16'h0000, 1, 1, 0);
        checkOutput("s3NextBinary", 32'(bus.binary_out), 1);
        checkOutput("s3InReady", 32'(bus.in_ready), 1);
        applyStimulus(0, 16'h0000, 1, 1, 0);
        checkOutput("s3Drained", 32'(bus.out_valid), 0);

        // Randomized traffic until 1000 vectors have been accepted.
        startAcc = mdlAccepted;
        cycles   = 0;
        while ((mdlAccepted - startAcc) < 1000 && cycles < 20000) begin
            applyStimulus($urandom_range(0, 9) < 7, randVec(),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 19) == 0);
            cycles++;
        end
        checkOutput("randAccepted", 32'(mdlAccepted - startAcc), 1000);
        cycles = 0;
        while (mdlQueue.size() != 0 && cycles < 10) begin
            applyStimulus(0, 16'h0000, 1, 1, 0);
            cycles++;
        end
        checkOutput("randDrained", 32'(bus.out_valid), 0);

        // A long run of all-ones inputs: error every time.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 16'hFFFF, 1, 1, 0);
        end
        checkOutput("s5Binary", 32'(bus.binary_out), 0);
        checkOutput("s5Err", 32'(bus.err_out), 1);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("s5Saturated", 32'(errCount), 255);
`endif
        applyStimulus(1, 16'hFFFF, 1, 1, 1);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("s5Cleared", 32'(errCount), 0);
`endif
        applyStimulus(0, 16'h0000, 1, 1, 0);

        // Reset while both entries are occupied.
        applyStimulus(1, 16'h0004, 0, 1, 0);
        applyStimulus(1, 16'h0008, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("s6OutValid", 32'(bus.out_valid), 0);
        checkOutput("s6InReady", 32'(bus.in_ready), 0);
        checkOutput("s6Binary", 32'(bus.binary_out), 0);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("s6Count", 32'(errCount), 0);
`endif
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 16'h0000, 1, 1, 0);
        checkOutput("s6Armed", 32'(bus.in_ready), 1);
        applyStimulus(1, 16'h8000, 1, 1, 0);
        checkOutput("s6Valid", 32'(bus.out_valid), 1);
        checkOutput("s6TopBinary", 32'(bus.binary_out), 15);
        checkOutput("s6TopErr", 32'(bus.err_out), 0);
        applyStimulus(0, 16'h0000, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_register.md
ONEHOT_ENCODER_REGISTER -- requirements
Module: onehot_encoder_register

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16: one-hot input vector width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 4: binary index width; INPUT_WIDTH SHALL equal 2^OUTPUT_WIDTH.
REQ-003 SHALL have parameter ERRCNT_WIDTH, default 8: error counter width.
REQ-004 SHALL have clk  input  1  clock, rising-edge active.
REQ-005 SHALL have rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have enable  input  1  gates acceptance of new input.
REQ-007 SHALL have in_valid  input  1  upstream vector valid.
REQ-008 SHALL have in_ready  output  1  block can accept a vector.
REQ-009 SHALL have onehot_in  input  INPUT_WIDTH  one-hot vector.
REQ-010 SHALL have out_valid  output  1  result valid.
REQ-011 SHALL have out_ready  input  1  downstream accepts result.
REQ-012 SHALL have binary_out  output  OUTPUT_WIDTH  encoded index.
REQ-013 SHALL have err_out  output  1  result came from a zero-hot or multi-hot vector.
REQ-014 SHALL have err_clr  input  1  synchronous error-counter clear (only with ONEHOT_ENC_ERRCNT_EN).
REQ-015 SHALL have err_count  output  ERRCNT_WIDTH  saturating error count (only with ONEHOT_ENC_ERRCNT_EN).

Function
REQ-016 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer SHALL occur with out_valid && out_ready.
REQ-017 Encoding SHALL be as follows: binary_out = index of the lowest set bit; all-zero input yields 0.
REQ-018 err_out SHALL be 1 when the input had zero bits set or more than one bit set, and 0 otherwise.
REQ-019 Storage SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, BUSY, FULL.
REQ-020 Transitions SHALL be: EMPTY+in_xfer->BUSY; BUSY+in_xfer+!out_xfer->FULL; BUSY+out_xfer+!in_xfer->EMPTY; BUSY+both->BUSY (main reloaded); FULL+out_xfer->BUSY (skid moves to main); all other cases hold.
REQ-021 in_ready SHALL equal enable && (state != FULL), with no combinational path from out_ready.
REQ-022 out_valid SHALL equal (state != EMPTY); binary_out and err_out SHALL come from the main entry.
REQ-023 Latency SHALL be as follows: vector accepted at edge N in EMPTY is presented at edge N+1.
REQ-024 Results SHALL leave in acceptance order, with no loss or duplication under any in/out_ready pattern.
REQ-025 binary_out and err_out SHALL be held stable while out_valid && !out_ready.
REQ-026 enable low SHALL block new acceptance only; buffered results still drain.

Reset
REQ-027 rst_n low SHALL asynchronously force: state EMPTY, out_valid 0, binary_out 0, err_out 0, err_count 0, skid contents 0.
REQ-028 in_ready SHALL be 0 while rst_n is low, and SHALL equal enable from the first edge after deassertion.
REQ-029 Reset mid-operation SHALL discard all buffered results.

Configuration
REQ-030 Macro ONEHOT_ENC_ERRCNT_EN defined: err_clr/err_count SHALL exist; the counter increments on each input transfer with an error condition, saturates at all-ones, and err_clr clears it to 0 (clear wins over a simultaneous increment).
REQ-031 Macro ONEHOT_ENC_ERRCNT_EN undefined: err_clr/err_count SHALL be absent, with no counter logic; all other behaviour identical.

Structure
REQ-032 Shared package onehot_pkg SHALL hold the state enum (EMPTY/BUSY/FULL) and the default width constants.
REQ-033 Sub-module onehot_check (combinational: lowest-set index, zero flag, multi-hot flag) SHALL be instantiated once on onehot_in.
REQ-034 An elaboration check SHALL error when INPUT_WIDTH != 2^OUTPUT_WIDTH.

Verification
REQ-035 Scenario: out_ready=1, send 0x0020 -> out_valid next cycle, binary_out=5, err_out=0.
REQ-036 Scenario: send 0x0000 then 0x0024 -> binary_out=0,err_out=1, then binary_out=2,err_out=1; err_count=2.
REQ-037 Scenario: out_ready=0, send 0x0001,0x0002 -> in_ready=0 after second; raise out_ready -> outputs 0 then 1 in order, in_ready=1.
REQ-038 Scenario: random in_valid/out_ready over 1000 vectors -> output sequence equals scoreboard, no drops.
REQ-039 Scenario: 300 consecutive 0xFFFF inputs -> err_count=255 held; err_clr with simultaneous error -> err_count=0.
REQ-040 Scenario: rst_n pulse while FULL -> out_valid=0 immediately, err_count=0, next vector 0x8000 -> binary_out=15.
